// File: rtl/audio_pkg.sv
// Shared fetch-state encoding, frame geometry and slot packing helper for the
// I2S FIFO player.
package audio_pkg;

  localparam int SLOT_BITS  = 32;
  localparam int FRAME_BITS = 64;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t ST_IDLE = 2'd0;
  localparam fetch_state_t ST_REQ  = 2'd1;
  localparam fetch_state_t ST_CAP  = 2'd2;

  // Slot image: one zero bit for the I2S delay, then the sample MSB first, then zero padding.
  function automatic logic [SLOT_BITS-1:0] slot_word(input logic [23:0] sample, input int nbits);
    logic [SLOT_BITS-1:0] w;
    w = {8'd0, sample};
    return w << (SLOT_BITS - 1 - nbits);
  endfunction

endpackage

// File: rtl/i2s_serializer.sv
// I2S master timing: free-running BCLK/LRCK, frame-boundary strobe and the
// MSB-first shift register that changes data on BCLK falling edges.
module i2s_serializer
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [FRAME_BITS-1:0] i_load_word,
  output logic                  o_frame_req,
  output logic                  o_bclk,
  output logic                  o_lrck,
  output logic                  o_sdata
);

  localparam int               DIV_W    = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);

  logic [DIV_W-1:0]      r_div_cnt;
  logic [5:0]            r_bit_cnt;
  logic [FRAME_BITS-1:0] r_shift;
  logic                  r_bclk;
  logic                  r_lrck;
  logic                  r_sdata;

  logic                  w_div_wrap;
  logic [DIV_W-1:0]      w_div_next;
  logic [5:0]            w_bit_next;

  assign w_div_wrap  = (r_div_cnt == DIV_LAST);
  assign w_div_next  = w_div_wrap ? DIV_W'(0) : r_div_cnt + DIV_W'(1);
  assign w_bit_next  = w_div_wrap ? r_bit_cnt + 6'd1 : r_bit_cnt;
  assign o_frame_req = (r_div_cnt == DIV_W'(0)) && (r_bit_cnt == 6'd0);

  // BCLK and LRCK are registered from the next count so they line up with div_cnt/bit_cnt.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_div_cnt <= DIV_W'(0);
      r_bit_cnt <= 6'd0;
      r_shift   <= {FRAME_BITS{1'b0}};
      r_bclk    <= 1'b0;
      r_lrck    <= 1'b0;
      r_sdata   <= 1'b0;
    end else begin
      r_div_cnt <= w_div_next;
      r_bit_cnt <= w_bit_next;
      r_bclk    <= (w_div_next >= DIV_HALF);
      r_lrck    <= w_bit_next[5];
      if (o_frame_req) begin
        r_shift <= i_load_word;
      end else if (w_div_wrap) begin
        r_sdata <= r_shift[FRAME_BITS-2];
        r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
      end else begin
        r_shift <= r_shift;
      end
    end
  end

  assign o_bclk  = r_bclk;
  assign o_lrck  = r_lrck;
  assign o_sdata = r_sdata;

endmodule

// File: rtl/i2s_fifo_player.sv
// Drains little-endian PCM bytes from the input FIFO into a one-frame holding
// buffer and hands complete frames to the I2S serializer at frame boundaries.
module i2s_fifo_player
  import audio_pkg::*;
#(
  parameter int BCLK_DIV         = 8,
  parameter int BYTES_PER_SAMPLE = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        rd_in_fifo_en_o,
  input  logic        rd_in_fifo_empty_i,
  input  logic [7:0]  rd_in_fifo_data_i,
  output logic        i2s_bclk_o,
  output logic        i2s_lrck_o,
  output logic        i2s_sdata_o,
  output logic        streaming_o,
  output logic        underrun_o,
  output logic [15:0] underrun_cnt_o
);

  localparam int               BYTES_PER_FRAME = 2 * BYTES_PER_SAMPLE;
  localparam int               SAMPLE_BITS     = 8 * BYTES_PER_SAMPLE;
  localparam int               IDX_W           = $clog2(BYTES_PER_FRAME);
  localparam logic [IDX_W-1:0] LAST_BYTE       = IDX_W'(BYTES_PER_FRAME - 1);

  fetch_state_t          r_state;
  logic                  r_rd_en;
  logic [IDX_W-1:0]      r_byte_idx;
  logic [7:0]            r_hold [BYTES_PER_FRAME];
  logic                  r_hold_valid;
  logic                  r_streaming;
  logic                  r_underrun;
  logic [15:0]           r_underrun_cnt;

  logic                  w_frame_req;
  logic [23:0]           w_left;
  logic [23:0]           w_right;
  logic [FRAME_BITS-1:0] w_load_word;

  // An empty holding buffer at a boundary plays a silent frame.
  always_comb begin
    w_left  = 24'd0;
    w_right = 24'd0;
    for (int i = 0; i < BYTES_PER_SAMPLE; i++) begin
      w_left[8*i +: 8]  = r_hold[i];
      w_right[8*i +: 8] = r_hold[BYTES_PER_SAMPLE + i];
    end
    if (r_hold_valid) begin
      w_load_word = {slot_word(w_left, SAMPLE_BITS), slot_word(w_right, SAMPLE_BITS)};
    end else begin
      w_load_word = {FRAME_BITS{1'b0}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= ST_IDLE;
      r_rd_en        <= 1'b0;
      r_byte_idx     <= IDX_W'(0);
      r_hold_valid   <= 1'b0;
      r_streaming    <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= 16'd0;
      for (int i = 0; i < BYTES_PER_FRAME; i++) begin
        r_hold[i] <= 8'd0;
      end
    end else begin
      r_underrun <= 1'b0;
      if (w_frame_req) begin
        if (r_hold_valid) begin
          r_hold_valid <= 1'b0;
          r_streaming  <= 1'b1;
        end else begin
          r_underrun <= 1'b1;
          if (r_underrun_cnt != 16'hFFFF) begin
            r_underrun_cnt <= r_underrun_cnt + 16'd1;
          end
        end
      end
      // The fetcher only runs while the buffer is invalid, so it never races the boundary clear.
      case (r_state)
        ST_IDLE: begin
          if (!r_hold_valid && !rd_in_fifo_empty_i) begin
            r_state <= ST_REQ;
            r_rd_en <= 1'b1;
          end
        end
        ST_REQ: begin
          r_rd_en <= 1'b0;
          r_state <= ST_CAP;
        end
        ST_CAP: begin
          r_hold[r_byte_idx] <= rd_in_fifo_data_i;
          if (r_byte_idx == LAST_BYTE) begin
            r_byte_idx   <= IDX_W'(0);
            r_hold_valid <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            r_byte_idx <= r_byte_idx + IDX_W'(1);
            if (!rd_in_fifo_empty_i) begin
              r_state <= ST_REQ;
              r_rd_en <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_rd_en <= 1'b0;
        end
      endcase
    end
  end

  i2s_serializer #(
    .BCLK_DIV(BCLK_DIV)
  ) u_serializer (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .i_load_word (w_load_word),
    .o_frame_req (w_frame_req),
    .o_bclk      (i2s_bclk_o),
    .o_lrck      (i2s_lrck_o),
    .o_sdata     (i2s_sdata_o)
  );

  assign rd_in_fifo_en_o = r_rd_en;
  assign streaming_o     = r_streaming;
  assign underrun_o      = r_underrun;
  assign underrun_cnt_o  = r_underrun_cnt;

endmodule

// File: tb/tb_i2s_fifo_player.sv
// Bench for i2s_fifo_player: a FIFO model, a cycle-level behavioural model of the
// player checked every cycle, and directed scenarios with literal expectations.
module tb_i2s_fifo_player;

  localparam int DIV   = 8;
  localparam int BPS   = 2;
  localparam int BPF   = 2 * BPS;
  localparam int NB    = 8 * BPS;
  localparam int FRAME = DIV * 64;

  logic        clk;
  logic        reset_i;
  logic        rd_in_fifo_en_o;
  logic        rd_in_fifo_empty_i;
  logic [7:0]  rd_in_fifo_data_i;
  logic        i2s_bclk_o;
  logic        i2s_lrck_o;
  logic        i2s_sdata_o;
  logic        streaming_o;
  logic        underrun_o;
  logic [15:0] underrun_cnt_o;

  int n_vec;
  int n_err;
  int cur;

  logic [7:0] mem [0:1023];
  int wp;
  int rp;

  int         m_x;
  int         m_nb;
  int         m_rp;
  int         m_ucnt;
  bit         m_en;
  bit         m_en_prev;
  bit         m_hv;
  bit         m_stream;
  bit         m_upulse;
  bit         prev_rst;
  logic [23:0] m_hl, m_hr, m_fl, m_fr;
  logic [7:0] m_bytes [BPF];
  logic [7:0] m_pend;

  i2s_fifo_player #(
    .BCLK_DIV(DIV),
    .BYTES_PER_SAMPLE(BPS)
  ) dut (
    .clk_i              (clk),
    .reset_i            (reset_i),
    .rd_in_fifo_en_o    (rd_in_fifo_en_o),
    .rd_in_fifo_empty_i (rd_in_fifo_empty_i),
    .rd_in_fifo_data_i  (rd_in_fifo_data_i),
    .i2s_bclk_o         (i2s_bclk_o),
    .i2s_lrck_o         (i2s_lrck_o),
    .i2s_sdata_o        (i2s_sdata_o),
    .streaming_o        (streaming_o),
    .underrun_o         (underrun_o),
    .underrun_cnt_o     (underrun_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source FIFO: data appears the cycle after a read strobe.
  assign rd_in_fifo_empty_i = (rp == wp);
  initial rd_in_fifo_data_i = 8'd0;
  always @(posedge clk) begin
    if (rd_in_fifo_en_o && (rp < wp)) begin
      rd_in_fifo_data_i <= mem[rp];
      rp <= rp + 1;
    end
  end

  task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [23:0] l, input logic [23:0] r, input int b);
    int k;
    logic [23:0] s;
    k = b % 32;
    s = (b >= 32) ? r : l;
    if (k >= 1 && k <= NB) return s[NB-k];
    else return 1'b0;
  endfunction

  task automatic model_reset();
    m_x = 0; m_nb = 0; m_ucnt = 0;
    m_en = 0; m_en_prev = 0; m_hv = 0; m_stream = 0; m_upulse = 0;
    m_hl = 24'd0; m_hr = 24'd0; m_fl = 24'd0; m_fr = 24'd0;
  endtask

  task automatic model_step();
    bit boundary, cap, last, next_en;
    boundary = (m_x % FRAME) == 0;
    cap      = m_en_prev;
    last     = cap && (m_nb == BPF - 1);
    next_en  = !rd_in_fifo_empty_i && !m_hv && !m_en && !last;
    m_upulse = 1'b0;
    if (boundary) begin
      if (m_hv) begin
        m_fl = m_hl; m_fr = m_hr; m_hv = 1'b0; m_stream = 1'b1;
      end else begin
        m_fl = 24'd0; m_fr = 24'd0; m_upulse = 1'b1;
        if (m_ucnt != 65535) m_ucnt++;
      end
    end
    if (cap) begin
      m_bytes[m_nb] = m_pend;
      if (last) begin
        m_hl = 24'd0; m_hr = 24'd0;
        for (int i = 0; i < BPS; i++) begin
          m_hl = m_hl | (24'(m_bytes[i]) << (8 * i));
          m_hr = m_hr | (24'(m_bytes[BPS + i]) << (8 * i));
        end
        m_hv = 1'b1; m_nb = 0;
      end else begin
        m_nb++;
      end
    end
    if (m_en) begin
      m_pend = mem[m_rp];
      m_rp++;
    end
    m_en_prev = m_en;
    m_en = next_en;
    m_x++;
  endtask

  // Per-cycle comparison against the behavioural model.
  initial begin
    prev_rst = 1'b0;
    m_rp = 0;
    m_pend = 8'd0;
    model_reset();
    forever begin
      @(negedge clk);
      if (reset_i) begin
        if (prev_rst) begin
          check("rst_rd_en", m_x, 32'(rd_in_fifo_en_o), 32'd0);
          check("rst_bclk", m_x, 32'(i2s_bclk_o), 32'd0);
          check("rst_lrck", m_x, 32'(i2s_lrck_o), 32'd0);
          check("rst_sdata", m_x, 32'(i2s_sdata_o), 32'd0);
          check("rst_stream", m_x, 32'(streaming_o), 32'd0);
          check("rst_underrun", m_x, 32'(underrun_o), 32'd0);
          check("rst_ucnt", m_x, 32'(underrun_cnt_o), 32'd0);
        end
        model_reset();
        prev_rst = 1'b1;
      end else begin
        prev_rst = 1'b0;
        check("rd_en", m_x, 32'(rd_in_fifo_en_o), 32'(m_en));
        check("bclk", m_x, 32'(i2s_bclk_o), 32'((m_x % DIV) >= DIV / 2));
        check("lrck", m_x, 32'(i2s_lrck_o), 32'(((m_x / DIV) % 64) >= 32));
        check("sdata", m_x, 32'(i2s_sdata_o), 32'(exp_bit(m_fl, m_fr, (m_x / DIV) % 64)));
        check("streaming", m_x, 32'(streaming_o), 32'(m_stream));
        check("underrun", m_x, 32'(underrun_o), 32'(m_upulse));
        check("ucnt", m_x, 32'(underrun_cnt_o), 32'(m_ucnt));
        model_step();
      end
    end
  end

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp = wp + 1;
  endtask

  task automatic sample_at(input int x);
    while (cur < x) begin
      @(posedge clk); #1;
      cur++;
    end
    #2;
  endtask

  task automatic start_reset();
    @(posedge clk); #1;
    reset_i = 1'b1;
  endtask

  task automatic end_reset(input int edges);
    repeat (edges) @(posedge clk);
    #1;
    reset_i = 1'b0;
    cur = 0;
  endtask

  task automatic read_slots(input int base, output logic [15:0] lw, output logic [15:0] rw);
    lw = 16'd0;
    rw = 16'd0;
    for (int k = 1; k <= 16; k++) begin
      sample_at(base + DIV * k + 4);
      lw = {lw[14:0], i2s_sdata_o};
    end
    for (int k = 33; k <= 48; k++) begin
      sample_at(base + DIV * k + 4);
      rw = {rw[14:0], i2s_sdata_o};
    end
  endtask

  // Directed scenarios with hand-computed expectations.
  initial begin
    logic [15:0] lw, rw, l, r;
    n_vec = 0; n_err = 0; cur = 0;
    wp = 0; rp = 0;
    reset_i = 1'b1;

    // Reset and free-running timing with an empty FIFO.
    start_reset();
    end_reset(3);
    sample_at(3);   check("t1_bclk_c3", cur, 32'(i2s_bclk_o), 32'd0);
    sample_at(4);   check("t1_bclk_c4", cur, 32'(i2s_bclk_o), 32'd1);
    sample_at(255); check("t1_lrck_c255", cur, 32'(i2s_lrck_o), 32'd0);
    sample_at(256); check("t1_lrck_c256", cur, 32'(i2s_lrck_o), 32'd1);
    sample_at(600);

    // Single frame 0x1234 / 0x5678.
    start_reset();
    push(8'h34); push(8'h12); push(8'h78); push(8'h56);
    end_reset(3);
    sample_at(512); check("t2_stream_before", cur, 32'(streaming_o), 32'd0);
    sample_at(513); check("t2_stream_after", cur, 32'(streaming_o), 32'd1);
    read_slots(512, lw, rw);
    check("t2_left", cur, 32'(lw), 32'h1234);
    check("t2_right", cur, 32'(rw), 32'h5678);

    // Empty FIFO for three frames.
    start_reset();
    end_reset(3);
    sample_at(513);  check("t3_pulse", cur, 32'(underrun_o), 32'd1);
    sample_at(514);  check("t3_pulse_end", cur, 32'(underrun_o), 32'd0);
    sample_at(1030); check("t3_ucnt", cur, 32'(underrun_cnt_o), 32'd3);
    check("t3_stream", cur, 32'(streaming_o), 32'd0);

    // Continuous nine-frame stream.
    start_reset();
    l = 16'hA5C3; r = 16'h3C5A;
    for (int i = 0; i < 9; i++) begin
      push(l[7:0]); push(l[15:8]); push(r[7:0]); push(r[15:8]);
      l = l + 16'h0F1E;
      r = r - 16'h1234;
    end
    end_reset(3);
    read_slots(512, lw, rw);
    check("t4_left0", cur, 32'(lw), 32'hA5C3);
    check("t4_right0", cur, 32'(rw), 32'h3C5A);
    read_slots(1024, lw, rw);
    check("t4_left1", cur, 32'(lw), 32'hB4E1);
    check("t4_right1", cur, 32'(rw), 32'h2A26);
    sample_at(4628);
    check("t4_ucnt", cur, 32'(underrun_cnt_o), 32'd1);
    check("t4_stream", cur, 32'(streaming_o), 32'd1);

    // Reset after two bytes of a frame have been captured.
    sample_at(4700);
    push(8'hAA); push(8'hBB);
    sample_at(4712);
    start_reset();
    push(8'h01); push(8'h00); push(8'h02); push(8'h00);
    repeat (2) @(posedge clk);
    #3;
    check("t5_rst_stream", cur, 32'(streaming_o), 32'd0);
    check("t5_rst_ucnt", cur, 32'(underrun_cnt_o), 32'd0);
    end_reset(2);
    read_slots(512, lw, rw);
    check("t5_left", cur, 32'(lw), 32'h0001);
    check("t5_right", cur, 32'(rw), 32'h0002);

    // Last byte captured in the boundary cycle.
    start_reset();
    end_reset(3);
    sample_at(504);
    push(8'hCD); push(8'hAB); push(8'h21); push(8'h43);
    sample_at(520);  check("t6_ucnt_boundary", cur, 32'(underrun_cnt_o), 32'd2);
    check("t6_stream_boundary", cur, 32'(streaming_o), 32'd0);
    sample_at(1030); check("t6_ucnt_next", cur, 32'(underrun_cnt_o), 32'd2);
    check("t6_stream_next", cur, 32'(streaming_o), 32'd1);
    read_slots(1024, lw, rw);
    check("t6_left", cur, 32'(lw), 32'hABCD);
    check("t6_right", cur, 32'(rw), 32'h4321);

    sample_at(1600);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
